// File: rtl/cirno_pkg.sv
// cirno_pkg: shared widths, halt encoding and fetch state type for the fetch sequencer
package cirno_pkg;
  localparam int DEF_PC_W = 10;
  localparam int DEF_INST_W = 9;
  localparam int DEF_TGT_W = 8;
  localparam int DEF_IMM_W = 6;
  localparam logic [8:0] DEF_HALT_INST = 9'h1FF;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: selects the next fetch address (start, absolute, pc-relative or sequential), modulo 2^PC_W
module next_pc_calc
  import cirno_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int TGT_W = DEF_TGT_W,
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic             first,
  input  logic             branch,
  input  logic             branchi,
  input  logic [PC_W-1:0]  start_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic [TGT_W-1:0] target,
  input  logic [IMM_W-1:0] immediate,
  output logic [PC_W-1:0]  addr
);
  logic [PC_W-1:0] tgt_ext, imm_ext;
  always_comb begin
    tgt_ext = PC_W'(target);
    imm_ext = PC_W'($signed(immediate));
    addr = first ? start_addr : branch ? tgt_ext : branchi ? pc + imm_ext : pc + PC_W'(1);
  end
endmodule

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: issues ROM reads for the next instruction and hands the word to the decoder
module inst_fetch_seq
  import cirno_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int INST_W = DEF_INST_W,
  parameter int TGT_W = DEF_TGT_W,
  parameter int IMM_W = DEF_IMM_W,
  parameter int ROM_LAT = 1,
  parameter logic [INST_W-1:0] HALT_INST = INST_W'(DEF_HALT_INST)
) (
  input  logic              clk,
  input  logic              init,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              fetch_en,
  input  logic              branch,
  input  logic              branchi,
  input  logic [TGT_W-1:0]  target,
  input  logic [IMM_W-1:0]  immediate,
  output logic [PC_W-1:0]   rom_addr,
  output logic              rom_rd_en,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done
);
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] rom_addr_q, rom_addr_d, pc_q, pc_d, next_addr;
  logic [INST_W-1:0] inst_q, inst_d;
  logic valid_q, valid_d, done_q, done_d, first_q, first_d, halt;
  logic [2:0] lat_q, lat_d;
  next_pc_calc #(.PC_W(PC_W), .TGT_W(TGT_W), .IMM_W(IMM_W)) u_npc (
    .first(first_q),
    .branch(branch),
    .branchi(branchi),
    .start_addr(start_addr),
    .pc(pc_q),
    .target(target),
    .immediate(immediate),
    .addr(next_addr)
  );
  always_comb begin
    state_d = state_q;
    rom_addr_d = rom_addr_q;
    pc_d = pc_q;
    inst_d = inst_q;
    valid_d = 1'b0;
    done_d = done_q;
    first_d = first_q;
    lat_d = lat_q;
    halt = rom_data == HALT_INST;
    case (state_q)
      IDLE: if (fetch_en) begin
        rom_addr_d = next_addr;
        first_d = 1'b0;
        state_d = REQ;
      end
      REQ: begin
        lat_d = 3'(ROM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (lat_q != 3'd0) lat_d = lat_q - 3'd1;
      else begin
        inst_d = rom_data;
        pc_d = rom_addr_q;
        valid_d = 1'b1;
        done_d = halt;
        state_d = halt ? HALTED : IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= IDLE;
      rom_addr_q <= '0;
      pc_q <= '0;
      inst_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      first_q <= 1'b1;
      lat_q <= '0;
    end else begin
      state_q <= state_d;
      rom_addr_q <= rom_addr_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      valid_q <= valid_d;
      done_q <= done_d;
      first_q <= first_d;
      lat_q <= lat_d;
    end
  end
  assign rom_addr = rom_addr_q;
  assign rom_rd_en = state_q == REQ;
  assign inst = inst_q;
  assign inst_valid = valid_q;
  assign pc = pc_q;
  assign busy = state_q == REQ || state_q == WAIT;
  assign done = done_q;
endmodule

// File: tb/tb_inst_fetch_seq.sv
// tb_inst_fetch_seq: scoreboard bench driving two sequencers (ROM latency 1 and 3) from shared stimulus
module tb_inst_fetch_seq;
  import cirno_pkg::*;
  typedef struct {
    int acc;
    logic [9:0] addr;
    logic [8:0] data;
  } item_t;
  logic clk = 1'b0, init = 1'b1;
  logic [9:0] start_addr = '0;
  logic fetch_en = 1'b0, branch = 1'b0, branchi = 1'b0;
  logic [7:0] target = '0;
  logic [5:0] immediate = '0;
  logic [9:0] rom_addr [2];
  logic rom_rd_en [2];
  logic [8:0] rom_data [2];
  logic [8:0] inst [2];
  logic inst_valid [2];
  logic [9:0] pc [2];
  logic busy [2];
  logic done [2];
  logic [8:0] mem [1024];
  logic [8:0] p1;
  logic [8:0] p3 [3];
  logic snap_rd [2];
  logic [9:0] snap_addr [2];
  int cyc = 0, checks = 0, errors = 0;
  int acc [2], avail [2], halt_at [2], mpc [2];
  bit first [2], halted [2];
  item_t sbq [2][$];
  always #5 clk = ~clk;
  inst_fetch_seq #(.ROM_LAT(1)) u_lat1 (
    .clk(clk), .init(init), .start_addr(start_addr), .fetch_en(fetch_en),
    .branch(branch), .branchi(branchi), .target(target), .immediate(immediate),
    .rom_addr(rom_addr[0]), .rom_rd_en(rom_rd_en[0]), .rom_data(rom_data[0]),
    .inst(inst[0]), .inst_valid(inst_valid[0]), .pc(pc[0]), .busy(busy[0]), .done(done[0])
  );
  inst_fetch_seq #(.ROM_LAT(3)) u_lat3 (
    .clk(clk), .init(init), .start_addr(start_addr), .fetch_en(fetch_en),
    .branch(branch), .branchi(branchi), .target(target), .immediate(immediate),
    .rom_addr(rom_addr[1]), .rom_rd_en(rom_rd_en[1]), .rom_data(rom_data[1]),
    .inst(inst[1]), .inst_valid(inst_valid[1]), .pc(pc[1]), .busy(busy[1]), .done(done[1])
  );
  assign rom_data[0] = p1;
  assign rom_data[1] = p3[2];
  function automatic int lat(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  task automatic chk(input string name, input int k, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat%0d cyc=%0d got=%0h exp=%0h", name, lat(k), cyc, act, exp);
    end
  endtask
  function automatic void model_reset(input int k);
    acc[k] = -100;
    avail[k] = 0;
    halt_at[k] = 0;
    mpc[k] = 0;
    first[k] = 1'b1;
    halted[k] = 1'b0;
  endfunction
  // synchronous ROMs: address sampled on the edge ending the strobe cycle, word appears ROM_LAT-1 edges later
  always @(posedge clk) begin
    p1 <= snap_rd[0] ? mem[snap_addr[0]] : 9'($urandom);
    p3[0] <= snap_rd[1] ? mem[snap_addr[1]] : 9'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (init) begin
        model_reset(k);
        sbq[k].delete();
      end else if (fetch_en && !halted[k] && cyc >= avail[k]) begin
        int a, off;
        item_t it;
        off = int'(immediate);
        if (off >= 32) off -= 64;
        a = first[k] ? int'(start_addr) : branch ? int'(target) :
            branchi ? (mpc[k] + off + 1024) % 1024 : (mpc[k] + 1) % 1024;
        first[k] = 1'b0;
        it.acc = cyc;
        it.addr = 10'(a);
        it.data = mem[a];
        sbq[k].push_back(it);
        acc[k] = cyc;
        avail[k] = cyc + 2 + lat(k);
        mpc[k] = a;
        if (mem[a] == DEF_HALT_INST) begin
          halted[k] = 1'b1;
          halt_at[k] = cyc + 1 + lat(k);
        end
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      snap_rd[k] = rom_rd_en[k];
      snap_addr[k] = rom_addr[k];
      if (!init) begin
        chk("busy", k, 40'(busy[k]), 40'(cyc >= acc[k] && cyc <= acc[k] + lat(k)));
        chk("done", k, 40'(done[k]), 40'(halted[k] && cyc >= halt_at[k]));
        if (rom_rd_en[k]) begin
          chk("rd_pending", k, 40'(sbq[k].size() > 0), 40'(1));
          if (sbq[k].size() > 0) begin
            chk("rd_addr", k, 40'(rom_addr[k]), 40'(sbq[k][0].addr));
            chk("rd_time", k, 40'(cyc), 40'(sbq[k][0].acc));
          end
        end
        if (inst_valid[k]) begin
          chk("valid_pending", k, 40'(sbq[k].size() > 0), 40'(1));
          if (sbq[k].size() > 0) begin
            item_t it;
            it = sbq[k].pop_front();
            chk("inst", k, 40'(inst[k]), 40'(it.data));
            chk("pc", k, 40'(pc[k]), 40'(it.addr));
            chk("valid_time", k, 40'(cyc), 40'(it.acc + 1 + lat(k)));
          end
        end
      end
    end
  end
  task automatic pulse_init(input int hold);
    @(negedge clk);
    #2 init = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_outs", k, 40'({rom_addr[k], rom_rd_en[k], inst[k], inst_valid[k], pc[k], busy[k], done[k]}), 40'(0));
      sbq[k].delete();
    end
    repeat (hold) @(negedge clk);
    init = 1'b0;
  endtask
  task automatic fetch(input bit br, input bit bi, input logic [7:0] t, input logic [5:0] im);
    @(negedge clk);
    fetch_en = 1'b1;
    branch = br;
    branchi = bi;
    target = t;
    immediate = im;
    @(negedge clk);
    fetch_en = 1'b0;
    branch = 1'($urandom);
    branchi = 1'($urandom);
    target = 8'($urandom);
    immediate = 6'($urandom);
    repeat (5) @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom_range(0, 510));
    mem[10'h010] = 9'h0A3;
    mem[10'h123] = DEF_HALT_INST;
    start_addr = 10'h010;
    pulse_init(2);
    fetch(0, 0, 8'h00, 6'h00);
    fetch(0, 0, 8'h00, 6'h00);
    fetch(0, 1, 8'h33, 6'b111110);
    fetch(1, 1, 8'hA5, 6'b000111);
    start_addr = 10'h001;
    pulse_init(1);
    fetch(0, 0, 8'h00, 6'h00);
    fetch(0, 1, 8'h00, 6'b111100);
    start_addr = 10'h3FF;
    pulse_init(1);
    fetch(0, 0, 8'h00, 6'h00);
    fetch(0, 0, 8'h00, 6'h00);
    @(negedge clk) fetch_en = 1'b1;
    @(negedge clk) fetch_en = 1'b0;
    @(negedge clk) fetch_en = 1'b1;
    @(negedge clk) fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    start_addr = 10'h123;
    pulse_init(1);
    fetch(0, 0, 8'h00, 6'h00);
    fetch(0, 0, 8'h00, 6'h00);
    fetch(1, 0, 8'h10, 6'h00);
    start_addr = 10'h050;
    pulse_init(1);
    @(negedge clk) fetch_en = 1'b1;
    @(negedge clk) fetch_en = 1'b0;
    pulse_init(1);
    repeat (4) @(negedge clk);
    fetch(0, 0, 8'h00, 6'h00);
    for (int i = 0; i < 1024; i++) mem[i] = $urandom_range(0, 49) == 0 ? DEF_HALT_INST : 9'($urandom);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        fetch_en = 1'b0;
        start_addr = 10'($urandom);
        pulse_init($urandom_range(1, 3));
      end else begin
        fetch_en = $urandom_range(0, 2) == 0;
        branch = $urandom_range(0, 3) == 0;
        branchi = $urandom_range(0, 2) == 0;
        target = 8'($urandom);
        immediate = 6'($urandom);
      end
    end
    @(negedge clk) fetch_en = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("drain", k, 40'(sbq[k].size()), 40'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
